bin_to_bcd_digit_streamer: RTL and testbench

//  Upstream feeder for the BCD->84-2-1 code converter. Accepts a binary word over a valid/ready

---
 rtl/bin_to_bcd_digit_streamer.sv | 135 +++++++++++++
 tb/tb_bin_to_bcd_digit_streamer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_digit_streamer.sv
// Sequential binary->BCD (double dabble), then streams BCD digits MSD first.
// Optional BCD_LZ_SUPPRESS_EN: skip leading zero digits (LSD always emitted).
module bin_to_bcd_digit_streamer #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_digit,
  output logic             out_last,
  output logic             out_enb,
  output logic             busy
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_cfg
    $error("DIGITS too small to hold 2**BIN_W-1");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    EMIT    = 2'd2
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [BIN_W-1:0] bin_q;
  logic [BW-1:0]    bcd_q;
  logic [BW-1:0]    bcd_adj;
  logic [BW-1:0]    bcd_sh;
  logic [BW-1:0]    sel_sh;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    idx_init;
  logic             accept;
  logic             beat;

  assign accept = in_valid & in_ready;
  assign beat   = out_valid & out_ready;

  // Per-nibble add-3, no carry between nibbles.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_sh = {bcd_adj[BW-2:0], bin_q[BIN_W-1]};

`ifdef BCD_LZ_SUPPRESS_EN
  // Start at the most-significant nonzero digit of the final value.
  always_comb begin
    idx_init = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] != 4'd0)
        idx_init = IW'(i);
    end
  end
`else
  assign idx_init = IW'(DIGITS - 1);
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept) state_n = CONVERT;
      CONVERT: if (cnt == '0) state_n = EMIT;
      EMIT:    if (beat && idx == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    sel_sh    = bcd_q >> {idx, 2'b00};
    in_ready  = (state == IDLE) & ~rst;
    out_valid = (state == EMIT);
    out_enb   = out_valid;
    busy      = (state == CONVERT) | (state == EMIT);
    out_last  = out_valid & (idx == '0);
    out_digit = out_valid ? sel_sh[3:0] : 4'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      unique case (1'b1)
        (state == IDLE): begin
          if (accept) begin
            bin_q <= in_bin;
            bcd_q <= '0;
            cnt   <= CW'(BIN_W - 1);
          end
        end
        (state == CONVERT): begin
          bin_q <= bin_q << 1;
          bcd_q <= bcd_sh;
          cnt   <= cnt - CW'(1);
          if (cnt == '0) idx <= idx_init;
        end
        (state == EMIT): begin
          if (beat && idx != '0) idx <= idx - IW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_digit_streamer.sv
// Self-checking bench for bin_to_bcd_digit_streamer (BIN_W=10, DIGITS=4).
// Honours BCD_LZ_SUPPRESS_EN when defined for both bench and design.
module tb_bin_to_bcd_digit_streamer;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_digit;
  logic             out_last;
  logic             out_enb;
  logic             busy;

  int checks = 0;
  int errors = 0;

  int exp_q[$];
  int got_q[$];
  bit got_last[$];

  bin_to_bcd_digit_streamer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_bin(in_bin),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_last(out_last), .out_enb(out_enb), .busy(busy)
  );

  always #5 clk = ~clk;

  // Decimal digits of v, MSD first, from plain arithmetic.
  function automatic void build_exp(input int v);
    int p;
    bit lead;
    exp_q.delete();
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
`ifdef BCD_LZ_SUPPRESS_EN
      if (lead && i > 0 && ((v / p) % 10) == 0) continue;
`endif
      lead = 1'b0;
      exp_q.push_back((v / p) % 10);
    end
  endfunction

  // Continuous output-property monitor, sampled on the falling edge.
  logic       pv, pr;
  logic [3:0] pd;
  logic       pl;
  initial begin pv = 0; pr = 0; pd = 0; pl = 0; end
  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (out_digit > 4'd9 || out_enb !== out_valid ||
          (!out_valid && out_digit !== 4'd0)) begin
        errors++;
        $display("FAIL prop: valid=%b enb=%b digit=%0d", out_valid, out_enb, out_digit);
      end
      if (pv && !pr) begin
        checks++;
        if (!out_valid || out_digit !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL stall_hold: valid=%b digit=%0d last=%b want digit=%0d last=%b",
                   out_valid, out_digit, out_last, pd, pl);
        end
      end
    end
    pv = out_valid & ~rst;
    pr = out_ready;
    pd = out_digit;
    pl = out_last;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL wait_ready: in_ready=%b want 1", in_ready);
    end
  endtask

  // Called at +1 after the acceptance edge.
  task automatic check_latency(input string nm);
    int rise;
    rise = -1;
    out_ready = 1'b0;
    for (int k = 0; k <= BIN_W; k++) begin
      if (out_valid && rise < 0) rise = k;
      if (k < BIN_W) tick();
    end
    checks++;
    if (rise != BIN_W) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", nm, rise, BIN_W);
    end
  endtask

  // mode 0: ready always; 1: 1,0,0 pattern; 2: random.
  task automatic collect(input int mode, input string nm);
    int c;
    bit done;
    got_q.delete();
    got_last.delete();
    c = 0;
    done = 1'b0;
    while (!done && c < 200) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = (c % 3) == 0;
        default: out_ready = 1'($urandom % 2);
      endcase
      if (out_valid && out_ready) begin
        got_q.push_back(int'(out_digit));
        got_last.push_back(out_last);
        done = out_last;
      end
      tick();
      c++;
    end
    out_ready = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: beats=%0d want last beat", nm, got_q.size());
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL %s ready_after: in_ready=%b want 1", nm, in_ready);
    end
  endtask

  task automatic compare(input int v, input string nm);
    bit bad;
    bad = (got_q.size() != exp_q.size());
    for (int i = 0; i < got_q.size() && !bad; i++) begin
      if (got_q[i] != exp_q[i]) bad = 1'b1;
      if (got_last[i] != (i == got_q.size() - 1)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL %s value %0d: got %p want %p", nm, v, got_q, exp_q);
    end
  endtask

  task automatic run_word(input int v, input int mode, input string nm);
    wait_ready();
    in_valid = 1'b1;
    in_bin = BIN_W'(v);
    tick();
    in_valid = 1'b0;
    check_latency(nm);
    collect(mode, nm);
    build_exp(v);
    compare(v, nm);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (in_ready || out_valid || out_digit != 0 || out_last || out_enb || busy) begin
        errors++;
        $display("FAIL reset: rdy=%b v=%b d=%0d l=%b e=%b b=%b want all 0",
                 in_ready, out_valid, out_digit, out_last, out_enb, busy);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b busy=%b want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_basic();
    run_word(937, 0, "w937");
    run_word(0, 0, "w0");
  endtask

  task automatic test_backpressure();
    run_word(1023, 1, "w1023");
  endtask

  task automatic test_busy_ignore();
    wait_ready();
    in_valid = 1'b1;
    in_bin = BIN_W'(500);
    tick();
    in_bin = BIN_W'(42);
    check_latency("hold500");
    collect(0, "hold500");
    build_exp(500);
    compare(500, "hold500");
    tick();
    in_valid = 1'b0;
    check_latency("hold42");
    collect(0, "hold42");
    build_exp(42);
    compare(42, "hold42");
  endtask

  task automatic test_reset_abort();
    wait_ready();
    in_valid = 1'b1;
    in_bin = BIN_W'(999);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy || out_valid) begin
      errors++;
      $display("FAIL abort_state: busy=%b valid=%b want 0 0", busy, out_valid);
    end
    run_word(8, 0, "after_abort");
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 200; n++) begin
      v = int'($urandom_range(0, 1023));
      run_word(v, 2, "rand");
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_bin = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    test_reset_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
